// File: rtl/lfsr_link_chk_pkg.sv
// Shared types and the LFSR step function for the LFSR link checker.
// The step shifts left and feeds the tap parity into bit 0, masked to the word width.
package lfsr_link_chk_pkg;

   localparam int MAX_DATA_WIDTH = 32;

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} lfsr_chk_state_t;

   function automatic logic [MAX_DATA_WIDTH-1:0] lfsr_step(
      input logic [MAX_DATA_WIDTH-1:0] state,
      input logic [MAX_DATA_WIDTH-1:0] taps,
      input int unsigned               width
   );
      logic [MAX_DATA_WIDTH-1:0] mask;
      logic                      fb;
      mask = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      fb   = ^(state & taps & mask);
      return ((state << 1) | {31'd0, fb}) & mask;
   endfunction

endpackage

// File: rtl/lfsr_link_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = {WIDTH{1'b0}};
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/lfsr_link_checker.sv
// Receive-side LFSR pattern checker: self-synchronising lock FSM plus saturating counters.
// Optional parity checking is enabled by defining LFSR_LINK_CHK_PARITY_EN.
module lfsr_link_checker
   import lfsr_link_chk_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] TAPS       = DATA_WIDTH'(8'hB8),
   parameter int                    LOCK_COUNT = 4,
   parameter int                    LOSS_COUNT = 3,
   parameter int                    CNT_BITS   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_parity,
   input  logic                  i_clear,
   output logic                  o_locked,
   output logic                  o_err_pulse,
   output logic [CNT_BITS-1:0]   o_err_cnt,
   output logic [CNT_BITS-1:0]   o_word_cnt,
   output logic [CNT_BITS-1:0]   o_parity_err_cnt
);

   // run counts the seeding word plus every good prediction, so lock needs LOCK_COUNT+1
   localparam int RUN_W  = $clog2(LOCK_COUNT + 2);
   localparam int MISS_W = $clog2(LOSS_COUNT + 1);
   localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_COUNT + 1);
   localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_COUNT);

   lfsr_chk_state_t       state_q, state_d;
   logic [DATA_WIDTH-1:0] pred_q, pred_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic [MISS_W-1:0]     miss_q, miss_d;
   logic                  err_pulse_q, err_pulse_d;

   logic [DATA_WIDTH-1:0] step_data_s;
   logic [DATA_WIDTH-1:0] step_pred_s;
   logic                  mismatch_s;
   logic                  par_fail_s;
   logic                  word_inc_s;
   logic                  err_inc_s;

   assign step_data_s = DATA_WIDTH'(lfsr_step(MAX_DATA_WIDTH'(i_data), MAX_DATA_WIDTH'(TAPS), DATA_WIDTH));
   assign step_pred_s = DATA_WIDTH'(lfsr_step(MAX_DATA_WIDTH'(pred_q), MAX_DATA_WIDTH'(TAPS), DATA_WIDTH));
   assign mismatch_s  = (i_data != pred_q);

`ifdef LFSR_LINK_CHK_PARITY_EN
   assign par_fail_s = i_parity ^ (^i_data);
`else
   logic unused_parity_s;
   assign unused_parity_s = i_parity;
   assign par_fail_s      = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= SEARCH;
         pred_q      <= {DATA_WIDTH{1'b0}};
         run_q       <= {RUN_W{1'b0}};
         miss_q      <= {MISS_W{1'b0}};
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pred_q      <= pred_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pred_d  = pred_q;
      run_d   = run_q;
      miss_d  = miss_q;
      if (i_valid) begin
         case (state_q)
            SEARCH: begin
               if (i_data == {DATA_WIDTH{1'b0}}) begin
                  run_d = {RUN_W{1'b0}};
               end else begin
                  pred_d = step_data_s;
                  if ((run_q != {RUN_W{1'b0}}) && !mismatch_s) begin
                     run_d = run_q + RUN_W'(1);
                  end else begin
                     run_d = RUN_W'(1);
                  end
                  if (run_d == RUN_LOCK) begin
                     state_d = LOCKED;
                     run_d   = {RUN_W{1'b0}};
                  end else begin
                     state_d = SEARCH;
                  end
               end
            end
            LOCKED: begin
               pred_d = step_pred_s;
               if (mismatch_s) begin
                  miss_d = miss_q + MISS_W'(1);
                  if (miss_d == MISS_LOSS) begin
                     state_d = SEARCH;
                     miss_d  = {MISS_W{1'b0}};
                     pred_d  = step_data_s;
                  end else begin
                     state_d = LOCKED;
                  end
               end else begin
                  miss_d = {MISS_W{1'b0}};
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_comb begin
      word_inc_s  = 1'b0;
      err_inc_s   = 1'b0;
      err_pulse_d = 1'b0;
      if (i_valid && (state_q == LOCKED)) begin
         word_inc_s  = 1'b1;
         err_inc_s   = mismatch_s;
         err_pulse_d = mismatch_s | par_fail_s;
      end else begin
         err_pulse_d = 1'b0;
      end
   end

   assign o_locked    = (state_q == LOCKED);
   assign o_err_pulse = err_pulse_q;

   sat_counter #(.WIDTH(CNT_BITS)) u_err_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (i_clear),
      .inc   (err_inc_s),
      .count (o_err_cnt)
   );

   sat_counter #(.WIDTH(CNT_BITS)) u_word_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (i_clear),
      .inc   (word_inc_s),
      .count (o_word_cnt)
   );

`ifdef LFSR_LINK_CHK_PARITY_EN
   sat_counter #(.WIDTH(CNT_BITS)) u_parity_cnt (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (i_clear),
      .inc   (i_valid & par_fail_s),
      .count (o_parity_err_cnt)
   );
`else
   assign o_parity_err_cnt = {CNT_BITS{1'b0}};
`endif

endmodule

// File: tb/tb_lfsr_link_checker.sv
// Bench for lfsr_link_checker: two instances (16-bit and 4-bit counters) against a word-level model.
module tb_lfsr_link_checker;

   localparam bit PAR_EN =
`ifdef LFSR_LINK_CHK_PARITY_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic [7:0] i_data = 8'h00;
   logic       i_parity = 1'b0;
   logic       i_clear = 1'b0;

   logic        lk16, pl16, lk4, pl4;
   logic [15:0] err16, word16, par16;
   logic [3:0]  err4, word4, par4;

   always #5 clk = ~clk;

   lfsr_link_checker #(.DATA_WIDTH(8), .TAPS(8'hB8), .LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_BITS(16)) dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_parity(i_parity),
      .i_clear(i_clear), .o_locked(lk16), .o_err_pulse(pl16), .o_err_cnt(err16),
      .o_word_cnt(word16), .o_parity_err_cnt(par16));

   lfsr_link_checker #(.DATA_WIDTH(8), .TAPS(8'hB8), .LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_BITS(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_parity(i_parity),
      .i_clear(i_clear), .o_locked(lk4), .o_err_pulse(pl4), .o_err_cnt(err4),
      .o_word_cnt(word4), .o_parity_err_cnt(par4));

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Word-level model state: expected flags and unbounded event counts
   bit         m_locked, m_have_prev, e_pulse;
   int         m_good, m_miss, c_err, c_word, c_par;
   logic [7:0] m_prev, m_pred, gw;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_step(input logic [7:0] s);
      logic fb;
      logic [7:0] taps;
      taps = 8'hB8;
      fb = 1'b0;
      for (int i = 0; i < 8; i++) if (taps[i]) fb = fb ^ s[i];
      return {s[6:0], fb};
   endfunction

   function automatic int sat(input int c, input int bits);
      int mx;
      mx = (1 << bits) - 1;
      return (c > mx) ? mx : c;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_have_prev = 0; e_pulse = 0;
      m_good = 0; m_miss = 0; c_err = 0; c_word = 0; c_par = 0;
      m_prev = 8'h00; m_pred = 8'h00;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit pbad, input bit clr);
      bit pf;
      pf = PAR_EN && pbad;
      e_pulse = 0;
      if (v) begin
         if (!m_locked) begin
            if (d == 8'h00) begin
               m_have_prev = 0;
               m_good = 0;
            end else begin
               if (m_have_prev && d == ref_step(m_prev)) m_good++;
               else m_good = 0;
               m_have_prev = 1;
               m_prev = d;
               if (m_good == 4) begin
                  m_locked = 1; m_good = 0; m_miss = 0; m_have_prev = 0;
                  m_pred = ref_step(d);
               end
            end
         end else begin
            c_word++;
            e_pulse = (d != m_pred) || pf;
            if (d != m_pred) begin
               c_err++;
               m_miss++;
            end else begin
               m_miss = 0;
            end
            m_pred = ref_step(m_pred);
            if (m_miss == 3) begin
               m_locked = 0; m_miss = 0; m_have_prev = 0;
            end
         end
         if (pf) c_par++;
      end
      if (clr) begin
         c_err = 0; c_word = 0; c_par = 0;
      end
   endtask

   task automatic send(input bit v, input logic [7:0] d, input bit pbad, input bit clr);
      i_valid  = v;
      i_data   = d;
      i_parity = (^d) ^ pbad;
      i_clear  = clr;
      @(posedge clk);
      model_step(v, d, pbad, clr);
      #1;
      i_valid = 1'b0;
      i_clear = 1'b0;
   endtask

   task automatic send_gen(input logic [7:0] flip, input bit pbad, input bit clr);
      send(1'b1, gw ^ flip, pbad, clr);
      gw = ref_step(gw);
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("locked16", 32'(lk16), 32'(m_locked));
         check("pulse16", 32'(pl16), 32'(e_pulse));
         check("err16", 32'(err16), 32'(sat(c_err, 16)));
         check("word16", 32'(word16), 32'(sat(c_word, 16)));
         check("par16", 32'(par16), 32'(sat(c_par, 16)));
         check("locked4", 32'(lk4), 32'(m_locked));
         check("pulse4", 32'(pl4), 32'(e_pulse));
         check("err4", 32'(err4), 32'(sat(c_err, 4)));
         check("word4", 32'(word4), 32'(sat(c_word, 4)));
         check("par4", 32'(par4), 32'(sat(c_par, 4)));
      end
   end

   initial begin
      int g;
      model_reset();
      #12;
      check("rst_locked", 32'(lk16), 32'd0);
      check("rst_pulse", 32'(pl16), 32'd0);
      check("rst_err", 32'(err16), 32'd0);
      check("rst_word", 32'(word16), 32'd0);
      check("rst_par", 32'(par16), 32'd0);
      check("step_AE", 32'(ref_step(8'hAE)), 32'h5D);
      check("step_5D", 32'(ref_step(8'h5D)), 32'hBA);
      check("step_BA", 32'(ref_step(8'hBA)), 32'h74);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      // Clean stream: lock one cycle after the 5th word
      gw = 8'hAE;
      for (int i = 0; i < 4; i++) send_gen(8'h00, 1'b0, 1'b0);
      check("lock_after4", 32'(lk16), 32'd0);
      send_gen(8'h00, 1'b0, 1'b0);
      check("lock_after5", 32'(lk16), 32'd1);
      for (int i = 0; i < 5; i++) send_gen(8'h00, 1'b0, 1'b0);
      check("words_after10", 32'(word16), 32'd5);
      check("err_after10", 32'(err16), 32'd0);

      // Single bit flip on the 3rd locked word of this burst
      send_gen(8'h00, 1'b0, 1'b0);
      send_gen(8'h00, 1'b0, 1'b0);
      send_gen(8'h01, 1'b0, 1'b0);
      check("flip_pulse", 32'(pl16), 32'd1);
      check("flip_err", 32'(err16), 32'd1);
      send_gen(8'h00, 1'b0, 1'b0);
      check("flip_next_pulse", 32'(pl16), 32'd0);
      check("flip_locked", 32'(lk16), 32'd1);
      send_gen(8'h00, 1'b0, 1'b0);

      // Three consecutive corruptions drop lock; clean words relock
      send_gen(8'h01, 1'b0, 1'b0);
      send_gen(8'h01, 1'b0, 1'b0);
      check("loss_locked2", 32'(lk16), 32'd1);
      send_gen(8'h01, 1'b0, 1'b0);
      check("loss_locked3", 32'(lk16), 32'd0);
      check("loss_err", 32'(err16), 32'd4);
      for (int i = 0; i < 4; i++) send_gen(8'h00, 1'b0, 1'b0);
      check("relock_4", 32'(lk16), 32'd0);
      send_gen(8'h00, 1'b0, 1'b0);
      check("relock_5", 32'(lk16), 32'd1);

      send(1'b0, 8'h00, 1'b0, 1'b1);
      check("clear_word", 32'(word16), 32'd0);
      check("clear_err", 32'(err16), 32'd0);

      // Saturation: 20 errors interleaved with clean words to stay locked
      for (int i = 0; i < 10; i++) begin
         send_gen(8'h80, 1'b0, 1'b0);
         send_gen(8'h80, 1'b0, 1'b0);
         send_gen(8'h00, 1'b0, 1'b0);
      end
      check("sat_err4", 32'(err4), 32'hF);
      check("sat_err16", 32'(err16), 32'd20);
      check("sat_word4", 32'(word4), 32'hF);

      // Clear coinciding with an error
      send_gen(8'h02, 1'b0, 1'b1);
      check("clr_err_pulse", 32'(pl16), 32'd1);
      check("clr_err16", 32'(err16), 32'd0);
      check("clr_err4", 32'(err4), 32'd0);
      check("clr_word16", 32'(word16), 32'd0);

      // Parity inversion on two clean words
      send_gen(8'h00, 1'b1, 1'b0);
      check("par_pulse", 32'(pl16), PAR_EN ? 32'd1 : 32'd0);
      send_gen(8'h00, 1'b0, 1'b0);
      send_gen(8'h00, 1'b1, 1'b0);
      check("par_cnt", 32'(par16), PAR_EN ? 32'd2 : 32'd0);
      check("par_err_cnt", 32'(err16), 32'd0);

      // Asynchronous reset mid-lock
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_locked", 32'(lk16), 32'd0);
      check("async_word", 32'(word16), 32'd0);
      #20;
      rst_n = 1'b1;

      // Idle gaps with a zero word injected during search
      gw = 8'hAE;
      g = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) send(1'b1, 8'h00, 1'b0, 1'b0);
         else send_gen(8'h00, 1'b0, 1'b0);
         if (i == 5) check("gap_no_lock", 32'(lk16), 32'd0);
         if (i == 7) check("gap_lock", 32'(lk16), 32'd1);
         repeat (g % 8) send(1'b0, 8'h00, 1'b0, 1'b0);
         g += 3;
      end
      for (int i = 0; i < 6; i++) begin
         send_gen(8'h00, 1'b0, 1'b0);
         repeat (i) send(1'b0, 8'h00, 1'b0, 1'b0);
      end
      check("gap_words", 32'(word16), 32'd6);
      check("gap_err", 32'(err16), 32'd0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
